// File: rtl/vga_timing_gen_if.sv
// Request/colour channel between the timing generator (master) and the renderer (slave).
interface vga_timing_gen_if #(
   parameter int unsigned X_W = 11,
   parameter int unsigned Y_W = 10
);
   logic [X_W-1:0] req_x;
   logic [Y_W-1:0] req_y;
   logic           req_active;
   logic [7:0]     pix_rgb;

   modport master (output req_x, output req_y, output req_active, input pix_rgb);
   modport slave  (input req_x, input req_y, input req_active, output pix_rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// Programmable VGA timing generator: divided pixel tick, renderer request channel,
// latency-matched sync/blank/colour outputs, run/stop at frame boundaries.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 800,
   parameter int unsigned H_FP     = 40,
   parameter int unsigned H_SYNC   = 128,
   parameter int unsigned H_BP     = 88,
   parameter int unsigned V_ACTIVE = 600,
   parameter int unsigned V_FP     = 1,
   parameter int unsigned V_SYNC   = 4,
   parameter int unsigned V_BP     = 23,
   parameter int unsigned HS_POL   = 1,
   parameter int unsigned VS_POL   = 1,
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned PIX_LAT  = 1,
   parameter int unsigned X_W      = 11,
   parameter int unsigned Y_W      = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   vga_timing_gen_if.master rnd,
   output logic             frame_start,
   output logic [15:0]      frame_cnt,
   output logic             VGA_HS,
   output logic             VGA_VS,
   output logic [2:0]       VGA_R,
   output logic [2:0]       VGA_G,
   output logic [1:0]       VGA_B,
   output logic             vga_de
);
   localparam int unsigned H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
   localparam int unsigned HS_END = HS_BEG + H_SYNC - 1;
   localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
   localparam int unsigned VS_END = VS_BEG + V_SYNC - 1;
   localparam int unsigned DIV_W  = 4;
   localparam logic        HS_ON  = 1'(HS_POL);
   localparam logic        VS_ON  = 1'(VS_POL);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [DIV_W-1:0] r_div;
   logic             w_pe;
   logic [0:0]       r_state;
   logic [0:0]       w_state_nxt;
   logic [X_W-1:0]   r_h;
   logic [X_W-1:0]   w_h_nxt;
   logic [Y_W-1:0]   r_v;
   logic [Y_W-1:0]   w_v_nxt;
   logic             w_start;
   logic             w_act_nxt;
   logic             w_hs_nxt;
   logic             w_vs_nxt;
   logic             r_active;
   logic             r_fs;
   logic [15:0]      r_fcnt;
   logic [2:0]       r_pipe [PIX_LAT];
   logic [2:0]       w_tail;
   logic [7:0]       r_rgb;
   logic             r_de;
   logic             r_hs;
   logic             r_vs;

   // Pixel-clock divider
   assign w_pe = (r_div == DIV_W'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      r_div <= '0;
      else if (w_pe) r_div <= '0;
      else           r_div <= r_div + DIV_W'(1);
   end

   // Next state and next raster position
   always_comb begin
      w_state_nxt = r_state;
      w_h_nxt     = r_h;
      w_v_nxt     = r_v;
      w_start     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_h_nxt = '0;
            w_v_nxt = '0;
            if (run) begin
               w_state_nxt = S_RUN;
               w_start     = 1'b1;
            end
         end
         S_RUN: begin
            if (r_h == X_W'(H_TOT - 1)) begin
               w_h_nxt = '0;
               if (r_v == Y_W'(V_TOT - 1)) begin
                  w_v_nxt = '0;
                  if (run) w_start     = 1'b1;
                  else     w_state_nxt = S_IDLE;
               end else begin
                  w_v_nxt = r_v + Y_W'(1);
               end
            end else begin
               w_h_nxt = r_h + X_W'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Attributes of the position about to be presented on req_*
   assign w_act_nxt = (w_state_nxt == S_RUN) && (w_h_nxt < X_W'(H_ACTIVE)) &&
                      (w_v_nxt < Y_W'(V_ACTIVE));
   assign w_hs_nxt  = (w_state_nxt == S_RUN) && (w_h_nxt >= X_W'(HS_BEG)) &&
                      (w_h_nxt <= X_W'(HS_END));
   assign w_vs_nxt  = (w_state_nxt == S_RUN) && (w_v_nxt >= Y_W'(VS_BEG)) &&
                      (w_v_nxt <= Y_W'(VS_END));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_h      <= '0;
         r_v      <= '0;
         r_active <= 1'b0;
      end else if (w_pe) begin
         r_state  <= w_state_nxt;
         r_h      <= w_h_nxt;
         r_v      <= w_v_nxt;
         r_active <= w_act_nxt;
      end
   end

   // Strobe lasts one clk even when ticks are several clks apart
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fs   <= 1'b0;
         r_fcnt <= '0;
      end else begin
         r_fs <= w_pe & w_start;
         if (w_pe & w_start) r_fcnt <= r_fcnt + 16'd1;
      end
   end

   // Delay pipe keeps shifting in IDLE so the last pixels of a frame drain out
   assign w_tail = r_pipe[PIX_LAT-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < PIX_LAT; i++) r_pipe[i] <= '0;
         r_rgb <= '0;
         r_de  <= 1'b0;
         r_hs  <= ~HS_ON;
         r_vs  <= ~VS_ON;
      end else if (w_pe) begin
         r_pipe[0] <= {w_act_nxt, w_hs_nxt, w_vs_nxt};
         for (int unsigned i = 1; i < PIX_LAT; i++) r_pipe[i] <= r_pipe[i-1];
         r_rgb <= w_tail[2] ? rnd.pix_rgb : 8'h00;
         r_de  <= w_tail[2];
         r_hs  <= w_tail[1] ~^ HS_ON;
         r_vs  <= w_tail[0] ~^ VS_ON;
      end
   end

   assign rnd.req_x      = r_h;
   assign rnd.req_y      = r_v;
   assign rnd.req_active = r_active;
   assign frame_start    = r_fs;
   assign frame_cnt      = r_fcnt;
   assign VGA_HS         = r_hs;
   assign VGA_VS         = r_vs;
   assign VGA_R          = r_rgb[7:5];
   assign VGA_G          = r_rgb[4:2];
   assign VGA_B          = r_rgb[1:0];
   assign vga_de         = r_de;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: two small-geometry instances (A: PIX_LAT 1, active-high syncs;
// B: PIX_LAT 3, active-low syncs) and one default-geometry instance (C).
module tb_vga_timing_gen;
   logic clk = 1'b0;
   logic rst;
   logic run;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   vga_timing_gen_if #(.X_W(4),  .Y_W(3))  if_a ();
   vga_timing_gen_if #(.X_W(4),  .Y_W(3))  if_b ();
   vga_timing_gen_if #(.X_W(11), .Y_W(10)) if_c ();

   logic        fs_a, fs_b, fs_c;
   logic [15:0] cnt_a, cnt_b, cnt_c;
   logic        hs_a, hs_b, hs_c, vs_a, vs_b, vs_c;
   logic [2:0]  r_a, r_b, r_c, g_a, g_b, g_c;
   logic [1:0]  b_a, b_b, b_c;
   logic        de_a, de_b, de_c;

   // Renderers: A combinational, B with three-tick latency, C constant
   logic [1:0] tb_div;
   logic [7:0] rb_d1, rb_d2;
   assign if_a.pix_rgb = {if_a.req_x[2:0], if_a.req_y[2:0], 2'b11};
   assign if_b.pix_rgb = rb_d2;
   assign if_c.pix_rgb = 8'hFF;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         tb_div <= 2'd0;
         rb_d1  <= 8'h00;
         rb_d2  <= 8'h00;
      end else if (tb_div == 2'd1) begin
         tb_div <= 2'd0;
         rb_d1  <= {if_b.req_x[2:0], if_b.req_y[2:0], 2'b11};
         rb_d2  <= rb_d1;
      end else begin
         tb_div <= tb_div + 2'd1;
      end
   end

   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
                    .V_SYNC(2), .V_BP(1), .HS_POL(1), .VS_POL(1), .CLK_DIV(2), .PIX_LAT(1),
                    .X_W(4), .Y_W(3)) u_a (
      .clk(clk), .rst(rst), .run(run), .rnd(if_a), .frame_start(fs_a), .frame_cnt(cnt_a),
      .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a), .vga_de(de_a));

   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
                    .V_SYNC(2), .V_BP(1), .HS_POL(0), .VS_POL(0), .CLK_DIV(2), .PIX_LAT(3),
                    .X_W(4), .Y_W(3)) u_b (
      .clk(clk), .rst(rst), .run(run), .rnd(if_b), .frame_start(fs_b), .frame_cnt(cnt_b),
      .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .vga_de(de_b));

   vga_timing_gen #(.CLK_DIV(2), .PIX_LAT(1)) u_c (
      .clk(clk), .rst(rst), .run(run), .rnd(if_c), .frame_start(fs_c), .frame_cnt(cnt_c),
      .VGA_HS(hs_c), .VGA_VS(vs_c), .VGA_R(r_c), .VGA_G(g_c), .VGA_B(b_c), .vga_de(de_c));

   // Expected {de, rgb, hs, vs} for small-geometry position index p (row-major, p<0 = none)
   function automatic logic [10:0] exp_out(input int p, input logic inv);
      logic       act, hs, vs;
      logic [7:0] rgb;
      act = (p >= 0) && (p % 16 < 8) && (p / 16 < 4);
      hs  = (p >= 0) && (p % 16 >= 10) && (p % 16 <= 12);
      vs  = (p >= 0) && (p / 16 >= 5) && (p / 16 <= 6);
      rgb = act ? {3'(p % 16), 3'(p / 16), 2'b11} : 8'h00;
      return {act, rgb, hs ^ inv, vs ^ inv};
   endfunction

   task automatic step_tick();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      run = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({if_a.req_x, if_a.req_y, if_a.req_active, fs_a, cnt_a} !== 25'd0) begin
         $display("FAIL reset_req_a got %h want 0",
                  {if_a.req_x, if_a.req_y, if_a.req_active, fs_a, cnt_a});
         errors++;
      end
      checks++;
      if ({de_a, r_a, g_a, b_a, hs_a, vs_a} !== 11'h000) begin
         $display("FAIL reset_out_a got %h want 000", {de_a, r_a, g_a, b_a, hs_a, vs_a});
         errors++;
      end
      checks++;
      if ({de_b, r_b, g_b, b_b, hs_b, vs_b} !== 11'h003) begin
         $display("FAIL reset_out_b got %h want 003", {de_b, r_b, g_b, b_b, hs_b, vs_b});
         errors++;
      end
   endtask

   // Release with run=1 and walk frame 1 tick by tick on A and B
   task automatic test_frame_walk();
      logic [24:0] exp_req;
      logic [10:0] exp_a, exp_b;
      run = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({fs_a, cnt_a} !== 17'd0) begin
         $display("FAIL first_edge_no_tick got %h want 0", {fs_a, cnt_a});
         errors++;
      end
      @(negedge clk);
      for (int t = 0; t <= 128; t++) begin
         int x, y;
         x = t % 16;
         y = (t / 16) % 8;
         exp_req = {4'(x), 3'(y), (x < 8) && (y < 4), (t == 0) || (t == 128),
                    (t < 128) ? 16'd1 : 16'd2};
         exp_a = exp_out(t - 1, 1'b0);
         exp_b = exp_out(t - 3, 1'b1);
         checks++;
         if ({if_a.req_x, if_a.req_y, if_a.req_active, fs_a, cnt_a} !== exp_req) begin
            $display("FAIL walk_req_a t=%0d got %h want %h", t,
                     {if_a.req_x, if_a.req_y, if_a.req_active, fs_a, cnt_a}, exp_req);
            errors++;
         end
         checks++;
         if ({de_a, r_a, g_a, b_a, hs_a, vs_a} !== exp_a) begin
            $display("FAIL walk_out_a t=%0d got %h want %h", t,
                     {de_a, r_a, g_a, b_a, hs_a, vs_a}, exp_a);
            errors++;
         end
         checks++;
         if ({de_b, r_b, g_b, b_b, hs_b, vs_b} !== exp_b) begin
            $display("FAIL walk_out_b t=%0d got %h want %h", t,
                     {de_b, r_b, g_b, b_b, hs_b, vs_b}, exp_b);
            errors++;
         end
         // Pixel (5,2) three ticks after req shows it: R=5 G=2 B=3
         if (t == 40) begin
            checks++;
            if ({de_b, r_b, g_b, b_b} !== {1'b1, 3'd5, 3'd2, 2'd3}) begin
               $display("FAIL lat3_pixel_5_2 got %h want 1ab", {de_b, r_b, g_b, b_b});
               errors++;
            end
         end
         if (t < 128) step_tick();
      end
   endtask

   task automatic test_stop_restart();
      repeat (35) step_tick();
      checks++;
      if ({if_a.req_x, if_a.req_y} !== {4'd3, 3'd2}) begin
         $display("FAIL stop_at_3_2 got %h want %h", {if_a.req_x, if_a.req_y}, {4'd3, 3'd2});
         errors++;
      end
      run = 1'b0;
      repeat (92) step_tick();
      checks++;
      if ({if_a.req_x, if_a.req_y, cnt_a} !== {4'd15, 3'd7, 16'd2}) begin
         $display("FAIL stop_completes_frame got %h want %h",
                  {if_a.req_x, if_a.req_y, cnt_a}, {4'd15, 3'd7, 16'd2});
         errors++;
      end
      step_tick();
      checks++;
      if ({if_a.req_x, if_a.req_y, if_a.req_active, fs_a, cnt_a} !== {7'd0, 2'b00, 16'd2}) begin
         $display("FAIL enter_idle got %h want %h",
                  {if_a.req_x, if_a.req_y, if_a.req_active, fs_a, cnt_a}, {7'd0, 2'b00, 16'd2});
         errors++;
      end
      repeat (4) step_tick();
      checks++;
      if ({if_a.req_x, if_a.req_y, if_a.req_active, fs_a, cnt_a} !== {7'd0, 2'b00, 16'd2}) begin
         $display("FAIL idle_hold got %h want %h",
                  {if_a.req_x, if_a.req_y, if_a.req_active, fs_a, cnt_a}, {7'd0, 2'b00, 16'd2});
         errors++;
      end
      checks++;
      if ({de_a, r_a, g_a, b_a, hs_a, vs_a, de_b, r_b, g_b, b_b, hs_b, vs_b} !== 22'h000003) begin
         $display("FAIL idle_outputs got %h want 000003",
                  {de_a, r_a, g_a, b_a, hs_a, vs_a, de_b, r_b, g_b, b_b, hs_b, vs_b});
         errors++;
      end
      run = 1'b1;
      @(negedge clk);
      checks++;
      if (fs_a !== 1'b0) begin
         $display("FAIL restart_no_early_fs got %b want 0", fs_a);
         errors++;
      end
      @(negedge clk);
      checks++;
      if ({if_a.req_x, if_a.req_y, if_a.req_active, fs_a, cnt_a} !== {7'd0, 2'b11, 16'd3}) begin
         $display("FAIL restart got %h want %h",
                  {if_a.req_x, if_a.req_y, if_a.req_active, fs_a, cnt_a}, {7'd0, 2'b11, 16'd3});
         errors++;
      end
   endtask

   task automatic test_async_reset();
      repeat (54) step_tick();
      checks++;
      if ({if_a.req_x, if_a.req_y, de_a, r_a, g_a, b_a} !== {4'd6, 3'd3, 1'b1, 8'hAF}) begin
         $display("FAIL pre_reset_6_3 got %h want %h",
                  {if_a.req_x, if_a.req_y, de_a, r_a, g_a, b_a}, {4'd6, 3'd3, 1'b1, 8'hAF});
         errors++;
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({if_a.req_x, if_a.req_y, if_a.req_active, fs_a, cnt_a} !== 25'd0) begin
         $display("FAIL async_req_a got %h want 0",
                  {if_a.req_x, if_a.req_y, if_a.req_active, fs_a, cnt_a});
         errors++;
      end
      checks++;
      if ({de_a, r_a, g_a, b_a, hs_a, vs_a, de_b, r_b, g_b, b_b, hs_b, vs_b} !== 22'h000003) begin
         $display("FAIL async_outputs got %h want 000003",
                  {de_a, r_a, g_a, b_a, hs_a, vs_a, de_b, r_b, g_b, b_b, hs_b, vs_b});
         errors++;
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (fs_a !== 1'b0) begin
         $display("FAIL rerelease_no_tick got %b want 0", fs_a);
         errors++;
      end
      @(negedge clk);
      checks++;
      if ({if_a.req_x, if_a.req_y, if_a.req_active, fs_a, cnt_a, fs_c, cnt_c} !==
          {7'd0, 2'b11, 16'd1, 1'b1, 16'd1}) begin
         $display("FAIL restart_after_reset got %h want %h",
                  {if_a.req_x, if_a.req_y, if_a.req_active, fs_a, cnt_a, fs_c, cnt_c},
                  {7'd0, 2'b11, 16'd1, 1'b1, 16'd1});
         errors++;
      end
   endtask

   // Default geometry: first line of C, sampled from the frame-start tick
   task automatic test_default_line();
      int hs_hi = 0;
      for (int t = 1; t <= 1056; t++) begin
         step_tick();
         if (hs_c) hs_hi++;
         if (t == 800 || t == 801 || t == 840 || t == 841 || t == 968 || t == 969) begin
            logic [1:0] exp_dh;
            exp_dh = {t == 800, t == 841 || t == 968};
            checks++;
            if ({de_c, hs_c} !== exp_dh) begin
               $display("FAIL default_de_hs t=%0d got %b want %b", t, {de_c, hs_c}, exp_dh);
               errors++;
            end
         end
         if (t == 1055) begin
            checks++;
            if ({if_c.req_x, if_c.req_y} !== {11'd1055, 10'd0}) begin
               $display("FAIL default_line_end got %h want %h",
                        {if_c.req_x, if_c.req_y}, {11'd1055, 10'd0});
               errors++;
            end
         end
      end
      checks++;
      if ({if_c.req_x, if_c.req_y, vs_c, cnt_c} !== {11'd0, 10'd1, 1'b0, 16'd1}) begin
         $display("FAIL default_line_wrap got %h want %h",
                  {if_c.req_x, if_c.req_y, vs_c, cnt_c}, {11'd0, 10'd1, 1'b0, 16'd1});
         errors++;
      end
      checks++;
      if (hs_hi !== 128) begin
         $display("FAIL default_hs_width got %0d want 128", hs_hi);
         errors++;
      end
   endtask

   initial begin
      test_reset();
      test_frame_walk();
      test_stop_restart();
      test_async_reset();
      test_default_line();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 800x600 VGA controller. Generates programmable H/V timing from the system clock through an integer pixel-clock divider.
- Issues pixel-coordinate requests to an external renderer (dino, obstacle and ground drawing logic) and accepts its colour a fixed PIX_LAT pixel ticks later.
- Delay-matches syncs and blanking to that colour. Adds run/stop at frame boundaries, a frame-start strobe and a frame counter.

Parameters:
- H_ACTIVE, 800: visible pixels per line
- H_FP, 40: horizontal front porch
- H_SYNC, 128: horizontal sync width
- H_BP, 88: horizontal back porch (H_TOT = 1056)
- V_ACTIVE, 600: visible lines
- V_FP, 1: vertical front porch
- V_SYNC, 4: vertical sync width
- V_BP, 23: vertical back porch (V_TOT = 628)
- HS_POL, 1: 1 = HS active-high, 0 = active-low
- VS_POL, 1: as HS_POL, for VS
- CLK_DIV, 2: clk cycles per pixel, 1..16
- PIX_LAT, 1: renderer latency in pixel ticks, 1..4
- X_W, 11: req_x width, must satisfy 2^X_W >= H_TOT
- Y_W, 10: req_y width, must satisfy 2^Y_W >= V_TOT

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- run  in  1  1 = generate frames; 0 = stop at the next frame boundary
- pix_rgb  in  8  renderer colour {R[2:0],G[2:0],B[1:0]}
- req_x  out  X_W  current horizontal count
- req_y  out  Y_W  current vertical count
- req_active  out  1  (req_x, req_y) is visible and the state is RUN
- frame_start  out  1  one-clk strobe at the start of each frame
- frame_cnt  out  16  frames started, wraps
- VGA_HS  out  1  horizontal sync
- VGA_VS  out  1  vertical sync
- VGA_R  out  3  red
- VGA_G  out  3  green
- VGA_B  out  2  blue
- vga_de  out  1  delayed data-enable

Behaviour:
- Divider: div counts 0..CLK_DIV-1 every clk. pe = (div == CLK_DIV-1). With CLK_DIV=1, pe is always 1. All counter, FSM and pipeline updates occur only on clk edges where pe=1 ("ticks"); frame_start is the only exception.
- States: IDLE, RUN.
- IDLE:
  - h = v = 0, req_active = 0.
  - On a tick with run = 1: go to RUN, h and v stay 0, pulse frame_start, increment frame_cnt.
- RUN:
  - On a tick, h increments.
  - At h = H_TOT-1: h wraps to 0 and v increments.
  - At h = H_TOT-1 and v = V_TOT-1 (last pixel of the frame):
    - If run = 1: h and v wrap to 0, pulse frame_start, increment frame_cnt.
    - If run = 0: go to IDLE.
  - Deasserting run mid-frame has no effect until that boundary; the frame always completes.
- req_active = RUN && h < H_ACTIVE && v < V_ACTIVE.
- Raw sync (before polarity):
  - hs_raw = H_ACTIVE+H_FP <= h <= H_ACTIVE+H_FP+H_SYNC-1; defaults give 840..967.
  - vs_raw = V_ACTIVE+V_FP <= v <= V_ACTIVE+V_FP+V_SYNC-1; defaults give 601..604.
  - In IDLE, hs_raw = vs_raw = 0.
- Timing contract:
  - Position P is on req_* during tick period n.
  - The renderer holds pix_rgb for P valid at tick n+PIX_LAT.
  - On tick n+PIX_LAT the output registers load:
    - RGB = pix_rgb if P active, else 0.
    - vga_de = P active.
    - VGA_HS = hs_raw(P) XNOR HS_POL.
    - VGA_VS = vs_raw(P) XNOR VS_POL.
  - A PIX_LAT-deep shift register of {active, hs_raw, vs_raw} carries P to that tick. It keeps shifting in IDLE, so trailing pixels drain.
- frame_start: high for exactly one clk cycle, coincident with the tick that starts the frame.
- frame_cnt: 16-bit, wraps FFFF -> 0000.
- Reset (rst = 0, asynchronous):
  - div, h, v, frame_cnt = 0; state = IDLE.
  - Delay pipe cleared to inactive.
  - RGB = 0, vga_de = 0, frame_start = 0.
  - VGA_HS = ~HS_POL, VGA_VS = ~VS_POL.
  - Asserting rst mid-frame truncates the frame immediately.
- Release: first tick on or after the first clk edge after rst deasserts.

Test Plan:
- Small config H 8/2/3/3 (H_TOT 16), V 4/1/2/1 (V_TOT 8), CLK_DIV=2, PIX_LAT=1, run=1. Release reset -> frame_start on the first tick. req_x steps 0..15 every 2 clk. HS raw high for x = 10..12, VS raw high for y = 5..6. frame_cnt = 1, then 2 after 256 clk.
- Renderer drives pix_rgb = {req_x[2:0], req_y[2:0], 2'b11}, PIX_LAT=3 -> pixel (5,2) appears as R=5, G=2, B=3 three ticks after req shows (5,2). RGB = 0 and vga_de = 0 at x >= 8. HS edges shifted by the same 3 ticks.
- HS_POL=0, VS_POL=0 -> VGA_HS low only for x = 10..12 and VGA_VS low only for y = 5..6. Both high during reset.
- Drop run at (3,2) -> frame completes to (15,7), then IDLE. req stays (0,0), outputs inactive, no frame_start. Raise run -> frame_start on the next tick, frame_cnt +1.
- Default parameters, CLK_DIV=2 -> 2112 clk per line, 1,326,336 clk per frame. HS active for 128 ticks starting at x=840. VS spans y = 601..604.
- Assert rst at (6,3) -> all outputs take reset values in the same cycle, asynchronously. After release -> restart at (0,0) with frame_cnt = 1.
